// File: rtl/new_usb_pkg.sv
// Shared types for the new_usb descriptor register chain: sequencer states and
// chain owner encoding.
package new_usb_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StHold
    } state_e;

    localparam logic OwnerPer  = 1'b0;
    localparam logic OwnerNper = 1'b1;

endpackage

// File: rtl/new_usb_registerchain_arb.sv
// Two-requester arbiter: periodic wins ties until it has taken MaxPerRun grants
// in a row while non-periodic was waiting, then non-periodic gets one turn.
module new_usb_registerchain_arb #(
    parameter int unsigned MaxPerRun = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic per_req_i,
    input  logic nper_req_i,
    output logic per_gnt_o,
    output logic nper_gnt_o
);

    localparam int unsigned RunWidth = $clog2(MaxPerRun + 1);

    logic [RunWidth-1:0] run_q;
    logic                run_max;

    assign run_max = (run_q == RunWidth'(MaxPerRun));

    always_comb begin
        per_gnt_o  = en_i & per_req_i & (~nper_req_i | ~run_max);
        nper_gnt_o = en_i & nper_req_i & (~per_req_i | run_max);
    end

    // Count only periodic grants that made non-periodic wait.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            run_q <= '0;
        end else if (nper_gnt_o) begin
            run_q <= '0;
        end else if (per_gnt_o) begin
            run_q <= nper_req_i ? run_q + RunWidth'(1) : '0;
        end
    end

endmodule

// File: rtl/new_usb_registerchain_ctrl.sv
// Sequencer for the new_usb descriptor register chain: grants one list
// processor, shifts its words into the chain, then holds it until done/flush.
module new_usb_registerchain_ctrl
    import new_usb_pkg::*;
#(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned Depth     = 8,
    parameter int unsigned LenWidth  = $clog2(Depth + 1),
    parameter int unsigned MaxPerRun = 4
) (
    input  logic                 soc_clk_i,
    input  logic                 soc_rst_i,
    input  logic                 per_req_i,
    input  logic [LenWidth-1:0]  per_len_i,
    output logic                 per_gnt_o,
    input  logic [DataWidth-1:0] per_data_i,
    input  logic                 per_valid_i,
    output logic                 per_ready_o,
    input  logic                 nper_req_i,
    input  logic [LenWidth-1:0]  nper_len_i,
    output logic                 nper_gnt_o,
    input  logic [DataWidth-1:0] nper_data_i,
    input  logic                 nper_valid_i,
    output logic                 nper_ready_o,
    output logic                 chain_shift_o,
    output logic [DataWidth-1:0] chain_data_o,
    output logic                 chain_clear_o,
    output logic                 chain_valid_o,
    output logic                 chain_owner_o,
    output logic [LenWidth-1:0]  chain_len_o,
    input  logic                 done_i,
    input  logic                 flush_i,
    output logic                 busy_o
);

    state_e               state_q;
    logic                 owner_q;
    logic [LenWidth-1:0]  len_q;
    logic [LenWidth-1:0]  cnt_q;

    logic                 grant_en;
    logic                 per_gnt;
    logic                 nper_gnt;
    logic [LenWidth-1:0]  gnt_len;
    logic [LenWidth-1:0]  sat_len;
    logic                 in_shift;
    logic                 owner_valid;
    logic [DataWidth-1:0] owner_data;
    logic                 accept;

    // Flush and reset both suppress any grant or word transfer in this cycle.
    assign grant_en = (state_q == StIdle) & ~flush_i & ~soc_rst_i;

    new_usb_registerchain_arb #(
        .MaxPerRun (MaxPerRun)
    ) u_arb (
        .clk_i      (soc_clk_i),
        .rst_i      (soc_rst_i),
        .en_i       (grant_en),
        .per_req_i  (per_req_i),
        .nper_req_i (nper_req_i),
        .per_gnt_o  (per_gnt),
        .nper_gnt_o (nper_gnt)
    );

    always_comb begin
        gnt_len     = nper_gnt ? nper_len_i : per_len_i;
        sat_len     = (gnt_len > LenWidth'(Depth)) ? LenWidth'(Depth) : gnt_len;
        in_shift    = (state_q == StShift) & ~flush_i & ~soc_rst_i;
        owner_valid = (owner_q == OwnerNper) ? nper_valid_i : per_valid_i;
        owner_data  = (owner_q == OwnerNper) ? nper_data_i : per_data_i;
        accept      = in_shift & owner_valid;
    end

    always_comb begin
        per_gnt_o     = per_gnt;
        nper_gnt_o    = nper_gnt;
        per_ready_o   = in_shift & (owner_q == OwnerPer);
        nper_ready_o  = in_shift & (owner_q == OwnerNper);
        chain_shift_o = accept;
        chain_data_o  = accept ? owner_data : '0;
        chain_clear_o = ~soc_rst_i & (flush_i | ((state_q == StHold) & done_i));
        chain_valid_o = (state_q == StHold);
        chain_owner_o = (state_q != StIdle) ? owner_q : 1'b0;
        chain_len_o   = (state_q != StIdle) ? len_q : '0;
        busy_o        = (state_q != StIdle);
    end

    always_ff @(posedge soc_clk_i) begin
        if (soc_rst_i) begin
            state_q <= StIdle;
            owner_q <= OwnerPer;
            len_q   <= '0;
            cnt_q   <= '0;
        end else if (flush_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (per_gnt | nper_gnt) begin
                        owner_q <= nper_gnt ? OwnerNper : OwnerPer;
                        len_q   <= sat_len;
                        cnt_q   <= '0;
                        state_q <= (sat_len == '0) ? StHold : StShift;
                    end
                end
                StShift: begin
                    if (accept) begin
                        if (cnt_q + LenWidth'(1) == len_q) begin
                            cnt_q   <= '0;
                            state_q <= StHold;
                        end else begin
                            cnt_q <= cnt_q + LenWidth'(1);
                        end
                    end
                end
                StHold: begin
                    if (done_i) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
